// File: rtl/pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit
//
// Program-counter register and instruction-fetch sequencer. It sits directly
// downstream of the next-PC mux. The block owns curr_pc and fetches the word
// at curr_pc over a valid/ready instruction-memory interface. It then offers
// the fetched word to decode with a valid/ready handshake. When decode takes
// the word, the block loads next_pc from the mux.
//
// Exactly one fetch is in flight at any time, and fetches never overlap. Each
// instruction therefore takes at least three cycles: REQ, WAIT and VALID.
//
// Ports
//   clk            core clock; all state changes on its rising edge
//   rst_n          synchronous active-low reset
//   fetch_en       run enable; a new fetch starts only while high
//   next_pc        next address from the next-PC mux
//   pc_ena         enable to the mux; high only on the decode handshake
//   curr_pc        current PC, fed back to the mux
//   imem_req_vld   instruction-memory request valid
//   imem_req_rdy   instruction-memory request ready
//   imem_req_addr  request address (always curr_pc)
//   imem_rsp_vld   response valid, single-cycle pulse
//   imem_rsp_data  response instruction word
//   imem_rsp_err   response bus error, qualified by imem_rsp_vld
//   inst_vld       instruction valid to decode
//   inst_rdy       decode ready
//   inst           fetched instruction
//   inst_pc        address of inst
//   fetch_err      sticky error flag (bus error or misaligned next_pc)
//   inst_cnt       number of instructions consumed by decode (wraps)
// -----------------------------------------------------------------------------
module pc_fetch_unit #(
    parameter int                   CPU_WIDTH = 32,
    parameter logic [CPU_WIDTH-1:0] RESET_PC  = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 fetch_en,
    input  logic [CPU_WIDTH-1:0] next_pc,
    output logic                 pc_ena,
    output logic [CPU_WIDTH-1:0] curr_pc,
    output logic                 imem_req_vld,
    input  logic                 imem_req_rdy,
    output logic [CPU_WIDTH-1:0] imem_req_addr,
    input  logic                 imem_rsp_vld,
    input  logic [CPU_WIDTH-1:0] imem_rsp_data,
    input  logic                 imem_rsp_err,
    output logic                 inst_vld,
    input  logic                 inst_rdy,
    output logic [CPU_WIDTH-1:0] inst,
    output logic [CPU_WIDTH-1:0] inst_pc,
    output logic                 fetch_err,
    output logic [CPU_WIDTH-1:0] inst_cnt
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_VALID = 3'd3;
    localparam logic [2:0] S_ERR   = 3'd4;

    localparam logic [CPU_WIDTH-1:0] CNT_ONE = {{(CPU_WIDTH-1){1'b0}}, 1'b1};

    logic [2:0]           state_q,    state_d;
    logic [CPU_WIDTH-1:0] curr_pc_q,  curr_pc_d;
    logic [CPU_WIDTH-1:0] inst_q,     inst_d;
    logic [CPU_WIDTH-1:0] inst_pc_q,  inst_pc_d;
    logic [CPU_WIDTH-1:0] inst_cnt_q, inst_cnt_d;

    logic dec_hs;        // decode accepts the instruction this cycle
    logic pc_misalign;   // next_pc is not word aligned

    assign dec_hs      = (state_q == S_VALID) && inst_rdy;
    assign pc_misalign = (next_pc[1:0] != 2'b00);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        curr_pc_d  = curr_pc_q;
        inst_d     = inst_q;
        inst_pc_d  = inst_pc_q;
        inst_cnt_d = inst_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (fetch_en) state_d = S_REQ;
            end

            // The request stays up with a stable address until memory takes
            // it. fetch_en cannot withdraw a request once it is offered.
            S_REQ: begin
                if (imem_req_rdy) state_d = S_WAIT;
            end

            // A bus error leaves inst untouched. Only the sticky flag
            // reports the error.
            S_WAIT: begin
                if (imem_rsp_vld) begin
                    if (imem_rsp_err) begin
                        state_d = S_ERR;
                    end else begin
                        inst_d    = imem_rsp_data;
                        inst_pc_d = curr_pc_q;
                        state_d   = S_VALID;
                    end
                end
            end

            // The PC loads the mux output even when it is misaligned. This
            // keeps the faulting address visible on curr_pc.
            S_VALID: begin
                if (inst_rdy) begin
                    curr_pc_d  = next_pc;
                    inst_cnt_d = inst_cnt_q + CNT_ONE;
                    if (pc_misalign)   state_d = S_ERR;
                    else if (fetch_en) state_d = S_REQ;
                    else               state_d = S_IDLE;
                end
            end

            // The block stays here until reset.
            S_ERR: begin
                state_d = S_ERR;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers. Reset overrides any event in the same cycle,
    // including a request or response in flight.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            curr_pc_q  <= RESET_PC;
            inst_q     <= '0;
            inst_pc_q  <= '0;
            inst_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            curr_pc_q  <= curr_pc_d;
            inst_q     <= inst_d;
            inst_pc_q  <= inst_pc_d;
            inst_cnt_q <= inst_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs. They are decoded straight from the state, so reset clears
    // every valid and flag without extra registers. pc_ena is the only
    // output that depends on an input in the same cycle.
    // ------------------------------------------------------------------
    assign imem_req_vld  = (state_q == S_REQ);
    assign imem_req_addr = curr_pc_q;
    assign inst_vld      = (state_q == S_VALID);
    assign fetch_err     = (state_q == S_ERR);
    assign pc_ena        = dec_hs;
    assign curr_pc       = curr_pc_q;
    assign inst          = inst_q;
    assign inst_pc       = inst_pc_q;
    assign inst_cnt      = inst_cnt_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main 32-bit instance
    logic        rst_n = 1'b0, fetch_en = 1'b0, imem_req_rdy = 1'b0;
    logic        imem_rsp_vld = 1'b0, imem_rsp_err = 1'b0, inst_rdy = 1'b0;
    logic [31:0] next_pc = '0, imem_rsp_data = '0;
    logic        pc_ena, imem_req_vld, inst_vld, fetch_err;
    logic [31:0] curr_pc, imem_req_addr, inst, inst_pc, inst_cnt;

    pc_fetch_unit #(.CPU_WIDTH(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .next_pc(next_pc),
        .pc_ena(pc_ena), .curr_pc(curr_pc), .imem_req_vld(imem_req_vld),
        .imem_req_rdy(imem_req_rdy), .imem_req_addr(imem_req_addr),
        .imem_rsp_vld(imem_rsp_vld), .imem_rsp_data(imem_rsp_data),
        .imem_rsp_err(imem_rsp_err), .inst_vld(inst_vld), .inst_rdy(inst_rdy),
        .inst(inst), .inst_pc(inst_pc), .fetch_err(fetch_err), .inst_cnt(inst_cnt)
    );

    // narrow instance: makes the instruction-counter wrap reachable
    logic       s_rst_n = 1'b0, s_en = 1'b0;
    logic       s_pc_ena, s_req_vld, s_inst_vld, s_err;
    logic [7:0] s_curr_pc, s_req_addr, s_inst, s_inst_pc, s_inst_cnt, s_next_pc;
    assign s_next_pc = s_curr_pc + 8'd4;

    pc_fetch_unit #(.CPU_WIDTH(8), .RESET_PC(8'h0)) dut8 (
        .clk(clk), .rst_n(s_rst_n), .fetch_en(s_en), .next_pc(s_next_pc),
        .pc_ena(s_pc_ena), .curr_pc(s_curr_pc), .imem_req_vld(s_req_vld),
        .imem_req_rdy(1'b1), .imem_req_addr(s_req_addr),
        .imem_rsp_vld(1'b1), .imem_rsp_data(8'h13),
        .imem_rsp_err(1'b0), .inst_vld(s_inst_vld), .inst_rdy(1'b1),
        .inst(s_inst), .inst_pc(s_inst_pc), .fetch_err(s_err), .inst_cnt(s_inst_cnt)
    );

    int errors = 0, checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each fetch moves through four steps: a request being offered, a
    // response awaited, an instruction held for decode, and done. The error
    // condition absorbs everything until reset.
    bit          m_known = 0, m_req = 0, m_out = 0, m_hold = 0, m_err = 0;
    logic [31:0] m_pc = 0, m_inst = 0, m_ipc = 0, m_cnt = 0;
    int          cyc_n = 0;
    int          hs_cyc[$];
    logic [31:0] hs_pc[$];
    // memory responder bookkeeping
    bit          mem_pending = 0;
    int          mem_delay = 0, mem_lat_max = 3;

    task automatic check_outputs();
        if (!m_known) return;
        chk("imem_req_vld",  {31'b0, imem_req_vld}, {31'b0, m_req});
        chk("imem_req_addr", imem_req_addr, m_pc);
        chk("curr_pc",       curr_pc, m_pc);
        chk("inst_vld",      {31'b0, inst_vld}, {31'b0, m_hold});
        chk("pc_ena",        {31'b0, pc_ena}, {31'b0, m_hold & inst_rdy});
        chk("fetch_err",     {31'b0, fetch_err}, {31'b0, m_err});
        chk("inst",          inst, m_inst);
        chk("inst_pc",       inst_pc, m_ipc);
        chk("inst_cnt",      inst_cnt, m_cnt);
    endtask

    task automatic model_step();
        if (!rst_n) begin
            m_known = 1; m_req = 0; m_out = 0; m_hold = 0; m_err = 0;
            m_pc = 32'h0; m_inst = 0; m_ipc = 0; m_cnt = 0;
            mem_pending = 0;
        end else if (!m_known || m_err) begin
            // nothing moves
        end else if (m_hold) begin
            if (inst_rdy) begin
                m_hold = 0;
                m_pc   = next_pc;
                m_cnt  = m_cnt + 1;
                if ((next_pc % 4) != 0) m_err = 1;
                else                    m_req = fetch_en;
            end
        end else if (m_out) begin
            if (imem_rsp_vld) begin
                m_out = 0;
                if (imem_rsp_err) m_err = 1;
                else begin m_hold = 1; m_inst = imem_rsp_data; m_ipc = m_pc; end
            end
        end else if (m_req) begin
            if (imem_req_rdy) begin
                m_req = 0; m_out = 1;
                mem_pending = 1;
                mem_delay = $urandom_range(0, mem_lat_max);
            end
        end else begin
            m_req = fetch_en;
        end
    endtask

    // one clock: check settled outputs, advance model, move to next negedge
    task automatic cyc();
        #1;
        check_outputs();
        if (pc_ena === 1'b1) begin hs_cyc.push_back(cyc_n); hs_pc.push_back(inst_pc); end
        model_step();
        cyc_n++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 0; fetch_en = 0; imem_req_rdy = 0; imem_rsp_vld = 0;
        imem_rsp_err = 0; inst_rdy = 0;
        cyc();
        rst_n = 1;
    endtask

    // run one instruction through to its decode handshake
    task automatic fetch_one(input logic [31:0] npc, input logic [31:0] data);
        logic [31:0] c0;
        bit          done;
        done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            fetch_en = 1; imem_req_rdy = 1; inst_rdy = 1;
            imem_rsp_vld = m_out; imem_rsp_data = data; imem_rsp_err = 0;
            next_pc = npc;
            c0 = m_cnt;
            cyc();
            if (m_cnt != c0) done = 1;
        end
        imem_rsp_vld = 0;
        checks++;
        if (!done) begin errors++; $display("FAIL fetch_one timeout: no handshake, expected one"); end
    endtask

    task automatic drive_mem();
        imem_rsp_data = $urandom;
        if (mem_pending) begin
            if (mem_delay == 0) begin
                imem_rsp_vld = 1; imem_rsp_err = ($urandom_range(0, 29) == 0);
                mem_pending = 0;
            end else begin
                mem_delay--; imem_rsp_vld = 0; imem_rsp_err = $urandom_range(0, 1);
            end
        end else begin
            imem_rsp_vld = ($urandom_range(0, 15) == 0);   // stray pulse, must be ignored
            imem_rsp_err = $urandom_range(0, 1);
        end
    endtask

    initial begin
        int hs8, r;
        @(negedge clk);

        // ---- reset values ----
        do_reset();
        rst_n = 0; cyc(); rst_n = 1;
        chk("rst curr_pc", curr_pc, 32'h0);
        chk("rst inst", inst, 32'h0);
        chk("rst inst_cnt", inst_cnt, 32'h0);
        chk("rst req_vld", {31'b0, imem_req_vld}, 32'h0);
        chk("rst inst_vld", {31'b0, inst_vld}, 32'h0);
        chk("rst fetch_err", {31'b0, fetch_err}, 32'h0);

        // ---- streaming fetch, 1-cycle memory, decode always ready ----
        fetch_en = 1; imem_req_rdy = 1; inst_rdy = 1;
        hs_cyc.delete(); hs_pc.delete();
        for (int k = 0; k < 13; k++) begin
            imem_rsp_vld = m_out; imem_rsp_data = 32'h0000_0013; imem_rsp_err = 0;
            next_pc = m_pc + 4;
            cyc();
        end
        imem_rsp_vld = 0;
        chk("stream inst_cnt", inst_cnt, 32'd4);
        chk("stream hs count", hs_pc.size(), 32'd4);
        for (int k = 0; k < 4 && k < hs_pc.size(); k++) chk("stream inst_pc", hs_pc[k], 32'(4 * k));
        for (int k = 1; k < hs_cyc.size(); k++) chk("stream pc_ena spacing", 32'(hs_cyc[k] - hs_cyc[k-1]), 32'd3);

        // ---- request stall with fetch_en toggling ----
        do_reset();
        fetch_en = 1; imem_req_rdy = 0; cyc();
        for (int i = 0; i < 5; i++) begin
            fetch_en = i[0];
            chk("stall req_vld", {31'b0, imem_req_vld}, 32'h1);
            chk("stall req_addr", imem_req_addr, 32'h0);
            cyc();
        end
        imem_req_rdy = 1; fetch_en = 0; cyc();
        chk("stall wait entered", {31'b0, imem_req_vld}, 32'h0);

        // ---- decode stall, then redirect to 0x100 ----
        imem_req_rdy = 0; imem_rsp_vld = 1; imem_rsp_data = 32'hABCD_0123;
        imem_rsp_err = 0; inst_rdy = 0; next_pc = 32'h100;
        cyc();
        imem_rsp_vld = 0;
        for (int i = 0; i < 4; i++) begin
            chk("dstall inst_vld", {31'b0, inst_vld}, 32'h1);
            chk("dstall inst", inst, 32'hABCD_0123);
            chk("dstall inst_pc", inst_pc, 32'h0);
            chk("dstall curr_pc", curr_pc, 32'h0);
            chk("dstall pc_ena", {31'b0, pc_ena}, 32'h0);
            cyc();
        end
        fetch_en = 1; inst_rdy = 1; #1;
        chk("dstall hs pc_ena", {31'b0, pc_ena}, 32'h1);
        cyc();
        chk("redirect curr_pc", curr_pc, 32'h100);
        chk("redirect req_addr", imem_req_addr, 32'h100);
        chk("redirect req_vld", {31'b0, imem_req_vld}, 32'h1);

        // ---- bus error response ----
        imem_req_rdy = 1; inst_rdy = 0; cyc();
        imem_rsp_vld = 1; imem_rsp_err = 1; imem_rsp_data = 32'hDEAD_BEEF; cyc();
        imem_rsp_vld = 0; imem_rsp_err = 0;
        chk("buserr fetch_err", {31'b0, fetch_err}, 32'h1);
        chk("buserr inst kept", inst, 32'hABCD_0123);
        for (int i = 0; i < 6; i++) begin
            fetch_en = 1; imem_req_rdy = 1; inst_rdy = 1;
            chk("buserr no req", {31'b0, imem_req_vld}, 32'h0);
            chk("buserr sticky", {31'b0, fetch_err}, 32'h1);
            cyc();
        end
        do_reset();
        chk("buserr cleared", {31'b0, fetch_err}, 32'h0);

        // ---- misaligned next_pc ----
        fetch_one(32'h102, 32'h13);
        chk("misalign curr_pc", curr_pc, 32'h102);
        chk("misalign fetch_err", {31'b0, fetch_err}, 32'h1);
        for (int i = 0; i < 3; i++) cyc();
        chk("misalign no req", {31'b0, imem_req_vld}, 32'h0);
        chk("misalign sticky", {31'b0, fetch_err}, 32'h1);

        // ---- reset in WAIT with a stale response after release ----
        do_reset();
        fetch_en = 1; imem_req_rdy = 1; cyc(); cyc();
        rst_n = 0; fetch_en = 0; cyc();
        rst_n = 1; imem_rsp_vld = 1; imem_rsp_data = 32'h5555_5555; cyc();
        imem_rsp_vld = 0;
        chk("stale inst_vld", {31'b0, inst_vld}, 32'h0);
        chk("stale inst", inst, 32'h0);
        chk("stale curr_pc", curr_pc, 32'h0);
        cyc();
        chk("stale inst_vld2", {31'b0, inst_vld}, 32'h0);

        // ---- PC wrap through the top of the address space ----
        do_reset();
        fetch_one(32'hFFFF_FFFC, 32'h11);
        chk("wrap curr_pc top", curr_pc, 32'hFFFF_FFFC);
        fetch_one(32'h0, 32'h22);
        chk("wrap inst_pc", hs_pc[$], 32'hFFFF_FFFC);
        chk("wrap curr_pc", curr_pc, 32'h0);
        chk("wrap req_addr", imem_req_addr, 32'h0);
        chk("wrap req_vld", {31'b0, imem_req_vld}, 32'h1);

        // ---- randomized traffic against the model ----
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            rst_n = !(($urandom_range(0, 199) == 0) || (m_err && $urandom_range(0, 7) == 0));
            fetch_en     = ($urandom_range(0, 7) != 0);
            imem_req_rdy = ($urandom_range(0, 2) != 0);
            inst_rdy     = ($urandom_range(0, 2) != 0);
            r = $urandom_range(0, 63);
            if (r == 0)      next_pc = ($urandom & ~32'h3) | 32'h1;
            else if (r < 6)  next_pc = $urandom & ~32'h3;
            else             next_pc = m_pc + 4;
            drive_mem();
            cyc();
        end
        rst_n = 0; imem_rsp_vld = 0;

        // ---- instruction counter wrap on the narrow instance ----
        s_rst_n = 0; @(negedge clk); @(negedge clk);
        s_rst_n = 1; s_en = 1;
        hs8 = 0;
        for (int i = 0; i < 1200 && hs8 < 260; i++) begin
            @(negedge clk);
            if (s_pc_ena) begin
                hs8++;
                @(negedge clk);
                chk("cnt8", {24'b0, s_inst_cnt}, 32'(hs8 % 256));
                if (hs8 == 256) chk("cnt8 wrap", {24'b0, s_inst_cnt}, 32'h0);
            end
        end
        checks++;
        if (hs8 < 260) begin errors++; $display("FAIL cnt8 timeout: %0d handshakes, expected 260", hs8); end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
